// File: rtl/odometer_meas_seq_mc.sv
// Multi-channel beat-frequency measurement sequencer. Counts reference cycles across NEDGE beat
// periods for each stress ROSC channel; results are read out through a scan shadow register.

module odometer_meas_seq_mc #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CW     = 10,
  parameter int unsigned NEDGE  = 2,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] ROSC_STRESS,
  input  logic           MEAS_TRIG,
  input  logic           SWEEP,
  input  logic [CHW-1:0] CH_REQ,
  input  logic           ABORT,
  output logic           EN_ROSC,
  output logic [CHW-1:0] CH_SEL,
  output logic           MEAS_BUSY,
  output logic           MEAS_DONE,
  input  logic           SCAN_LOAD,
  input  logic           SCAN_SHIFT,
  input  logic           SCAN_IN,
  output logic           SCAN_OUT
);

  localparam int unsigned SW = NCH * (CW + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StArm    = 3'd2;
  localparam logic [2:0] StCount  = 3'd3;
  localparam logic [2:0] StNext   = 3'd4;

  localparam logic [CW-1:0]  CntMax     = '1;
  localparam logic [CW-1:0]  SettleLast = (SETTLE > 1) ? CW'(SETTLE - 1) : '0;
  localparam logic [3:0]     EdgeLast   = 4'(NEDGE);
  localparam logic [CHW-1:0] ChLast     = CHW'(NCH - 1);

  logic [2:0]     state_q, state_d;
  logic [CHW-1:0] ch_sel_q, ch_sel_d;
  logic           sweep_q, sweep_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     edge_cnt_q, edge_cnt_d;
  logic [3:0]     edge_inc;
  logic           done_q, done_d;
  logic [1:0]     sync_q;
  logic [2:0]     hist_q;
  logic           stress_sel, det, enter_settle;
  logic           store, store_sat;
  logic [CW-1:0]  store_val;
  logic [CW-1:0]  res_q [NCH];
  logic [NCH-1:0] sat_q;
  logic [SW-1:0]  sh_q, sh_load;
  logic           scan_out_q;

  always_comb begin
    stress_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel_q == CHW'(i)) stress_sel = ROSC_STRESS[i];
    end
  end

  // hist_q[0] is the newest sample: a rise seen after two lows
  assign det      = hist_q[0] & ~hist_q[1] & ~hist_q[2];
  assign edge_inc = edge_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    ch_sel_d   = ch_sel_q;
    sweep_d    = sweep_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    done_d     = 1'b0;
    store      = 1'b0;
    store_sat  = 1'b0;
    store_val  = cnt_q + CW'(1);
    case (state_q)
      StIdle: begin
        if (MEAS_TRIG) begin
          sweep_d  = SWEEP;
          ch_sel_d = SWEEP ? '0 : CH_REQ;
          cnt_d    = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StArm;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StArm: begin
        if (det) begin
          cnt_d      = '0;
          edge_cnt_d = '0;
          state_d    = StCount;
        end else if (cnt_q == CntMax) begin
          store     = 1'b1;
          store_sat = 1'b1;
          state_d   = StNext;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StCount: begin
        // saturation takes precedence over a coincident edge
        if (cnt_q == CntMax) begin
          store     = 1'b1;
          store_sat = 1'b1;
          state_d   = StNext;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (det) begin
            edge_cnt_d = edge_inc;
            if (edge_inc == EdgeLast) begin
              store   = 1'b1;
              state_d = StNext;
            end
          end
        end
      end
      StNext: begin
        if (sweep_q && (ch_sel_q != ChLast)) begin
          ch_sel_d = ch_sel_q + CHW'(1);
          cnt_d    = '0;
          state_d  = StSettle;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (ABORT && (state_q != StIdle)) begin
      state_d  = StIdle;
      ch_sel_d = ch_sel_q;
      done_d   = 1'b1;
      store    = 1'b0;
    end
  end

  assign enter_settle = (state_d == StSettle) && (state_q != StSettle);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      ch_sel_q   <= '0;
      sweep_q    <= 1'b0;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      done_q     <= 1'b0;
      sync_q     <= 2'b11;
      hist_q     <= 3'b111;
      sat_q      <= '0;
      for (int i = 0; i < NCH; i++) res_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ch_sel_q   <= ch_sel_d;
      sweep_q    <= sweep_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      done_q     <= done_d;
      // Flush the synchronizer too, so stale samples of the previous channel cannot form an edge
      if (enter_settle) begin
        sync_q <= 2'b11;
        hist_q <= 3'b111;
      end else begin
        sync_q <= {sync_q[0], stress_sel};
        hist_q <= {hist_q[1:0], sync_q[1]};
      end
      for (int i = 0; i < NCH; i++) begin
        if (store && (ch_sel_q == CHW'(i))) begin
          res_q[i] <= store_sat ? CntMax : store_val;
          sat_q[i] <= store_sat;
        end
      end
    end
  end

  always_comb begin
    sh_load = '0;
    for (int i = 0; i < NCH; i++) sh_load[i*(CW+1) +: (CW+1)] = {sat_q[i], res_q[i]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_q       <= '0;
      scan_out_q <= 1'b0;
    end else if (SCAN_LOAD) begin
      sh_q       <= sh_load;
      scan_out_q <= sh_load[SW-1];
    end else if (SCAN_SHIFT) begin
      sh_q       <= {sh_q[SW-2:0], SCAN_IN};
      scan_out_q <= sh_q[SW-2];
    end
  end

  assign EN_ROSC   = (state_q == StSettle) || (state_q == StArm) || (state_q == StCount);
  assign CH_SEL    = ch_sel_q;
  assign MEAS_BUSY = (state_q != StIdle);
  assign MEAS_DONE = done_q;
  assign SCAN_OUT  = scan_out_q;

endmodule

// File: tb/tb_odometer_meas_seq_mc.sv
// Bench for odometer_meas_seq_mc: periodic stress waveforms with random periods and phases,
// expected results from beat-period arithmetic, readout through the scan chain.

module tb_odometer_meas_seq_mc;

  localparam int NCH    = 4;
  localparam int CW     = 10;
  localparam int NEDGE  = 2;
  localparam int SETTLE = 2;
  localparam int CHW    = 2;
  localparam int SW     = NCH * (CW + 1);
  localparam int BUDGET = 12000;
  localparam int RESMAX = (1 << CW) - 1;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [NCH-1:0] ROSC_STRESS;
  logic           MEAS_TRIG = 1'b0;
  logic           SWEEP = 1'b0;
  logic [CHW-1:0] CH_REQ = '0;
  logic           ABORT = 1'b0;
  logic           EN_ROSC;
  logic [CHW-1:0] CH_SEL;
  logic           MEAS_BUSY;
  logic           MEAS_DONE;
  logic           SCAN_LOAD = 1'b0;
  logic           SCAN_SHIFT = 1'b0;
  logic           SCAN_IN = 1'b0;
  logic           SCAN_OUT;

  int total  = 0;
  int passed = 0;

  int             per  [NCH];
  int             ph   [NCH];
  logic [NCH-1:0] cval = '0;
  int             mres [NCH];
  bit             msat [NCH];
  logic [SW-1:0]  vec;

  odometer_meas_seq_mc #(
    .NCH   (NCH),
    .CW    (CW),
    .NEDGE (NEDGE),
    .SETTLE(SETTLE)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ROSC_STRESS(ROSC_STRESS),
    .MEAS_TRIG  (MEAS_TRIG),
    .SWEEP      (SWEEP),
    .CH_REQ     (CH_REQ),
    .ABORT      (ABORT),
    .EN_ROSC    (EN_ROSC),
    .CH_SEL     (CH_SEL),
    .MEAS_BUSY  (MEAS_BUSY),
    .MEAS_DONE  (MEAS_DONE),
    .SCAN_LOAD  (SCAN_LOAD),
    .SCAN_SHIFT (SCAN_SHIFT),
    .SCAN_IN    (SCAN_IN),
    .SCAN_OUT   (SCAN_OUT)
  );

  always #5 CLK = ~CLK;

  // Square wave per channel: low for per/2 cycles, high for the rest; per==0 holds a constant
  initial begin
    ROSC_STRESS = '0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < NCH; i++) begin
        if (per[i] <= 0) begin
          ROSC_STRESS[i] = cval[i];
        end else begin
          ph[i] = (ph[i] + 1) % per[i];
          ROSC_STRESS[i] = (ph[i] >= per[i] / 2);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_per(input int ch, input int p);
    per[ch]  = p;
    ph[ch]   = (p > 0) ? int'($urandom_range(p - 1, 0)) : 0;
    cval[ch] = 1'($urandom_range(1, 0));
  endtask

  // Result is NEDGE whole beat periods in CLK cycles, clipped to all-ones with SAT
  task automatic model_meas(input int ch);
    int v;
    v = NEDGE * per[ch];
    if (per[ch] <= 0 || v > RESMAX) begin
      mres[ch] = RESMAX;
      msat[ch] = 1'b1;
    end else begin
      mres[ch] = v;
      msat[ch] = 1'b0;
    end
  endtask

  function automatic logic [SW-1:0] exp_vec();
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*(CW+1) +: (CW+1)] = {msat[i], CW'(mres[i])};
    return v;
  endfunction

  task automatic scan_stream(input bit ld, input bit sin, output logic [SW-1:0] v);
    if (ld) begin
      SCAN_LOAD = 1'b1;
      @(negedge CLK);
      SCAN_LOAD = 1'b0;
    end
    SCAN_IN    = sin;
    SCAN_SHIFT = 1'b1;
    for (int k = 0; k < SW; k++) begin
      v[SW-1-k] = SCAN_OUT;
      @(negedge CLK);
    end
    SCAN_SHIFT = 1'b0;
  endtask

  task automatic run_meas(input bit sw, input int ch, input int abort_at);
    int cyc, gaps, len;
    bit seen, ch_ok, gap_ok;
    cyc = 0; gaps = 0; len = 0; seen = 0; ch_ok = 1; gap_ok = 1;
    check("busy_before_trig", MEAS_BUSY, 0);
    SWEEP     = sw;
    CH_REQ    = CHW'(ch);
    MEAS_TRIG = 1'b1;
    @(negedge CLK);
    MEAS_TRIG = 1'b0;
    check("busy_rise", MEAS_BUSY, 1);
    while (!seen && cyc < BUDGET) begin
      if (MEAS_DONE) begin
        seen = 1;
      end else begin
        if (MEAS_BUSY && !EN_ROSC) begin
          len++;
        end else if (MEAS_BUSY) begin
          if (len > 0) begin
            if (len != 1) gap_ok = 0;
            gaps++;
            len = 0;
          end
          if (CH_SEL !== CHW'(sw ? gaps : ch)) ch_ok = 0;
        end
        // retrigger with a different channel request while busy: must be ignored
        MEAS_TRIG = (cyc == 10);
        if (cyc == 10) CH_REQ = CHW'(ch + 1);
        ABORT = (abort_at > 0) && (cyc == abort_at);
        @(negedge CLK);
        cyc++;
      end
    end
    ABORT     = 1'b0;
    MEAS_TRIG = 1'b0;
    check("done_seen", seen, 1);
    check("busy_at_done", MEAS_BUSY, 0);
    check("en_at_done", EN_ROSC, 0);
    check("ch_sel_track", ch_ok, 1);
    check("en_gap_len", gap_ok, 1);
    if (abort_at > 0) begin
      check("abort_latency", cyc, abort_at + 1);
    end else begin
      check("en_gap_count", gaps, sw ? NCH - 1 : 0);
      if (sw) for (int i = 0; i < NCH; i++) model_meas(i);
      else model_meas(ch);
    end
    @(negedge CLK);
    check("done_one_cycle", MEAS_DONE, 0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      per[i] = 0; ph[i] = 0; mres[i] = 0; msat[i] = 0;
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_en", EN_ROSC, 0);
    check("rst_chsel", CH_SEL, 0);
    check("rst_busy", MEAS_BUSY, 0);
    check("rst_done", MEAS_DONE, 0);
    check("rst_scan_out", SCAN_OUT, 0);
    RST = 1'b0;
    @(negedge CLK);
    scan_stream(1, 0, vec);
    check("rst_results", vec, exp_vec());

    // single channel, beat of 50 -> 100
    for (int i = 0; i < NCH; i++) set_per(i, int'($urandom_range(300, 6)));
    set_per(1, 50);
    repeat (4) @(negedge CLK);
    run_meas(0, 1, 0);
    scan_stream(1, 0, vec);
    check("single_ch1", vec, exp_vec());

    // sweep with 20/30/40/50 beats
    set_per(0, 20); set_per(1, 30); set_per(2, 40); set_per(3, 50);
    repeat (4) @(negedge CLK);
    run_meas(1, 0, 0);
    scan_stream(1, 1, vec);
    check("sweep_basic", vec, exp_vec());
    scan_stream(0, 0, vec);
    check("scan_refill_ones", vec, {SW{1'b1}});

    // channel 2 constant -> ARM timeout, sweep continues
    set_per(0, int'($urandom_range(400, 6))); set_per(1, int'($urandom_range(400, 6)));
    set_per(2, 0); set_per(3, int'($urandom_range(400, 6)));
    repeat (4) @(negedge CLK);
    run_meas(1, 0, 0);
    scan_stream(1, 0, vec);
    check("sweep_timeout", vec, exp_vec());

    // counter saturation, edge on the saturation cycle, largest unsaturated value
    set_per(0, 600); set_per(3, 512); set_per(1, 511);
    repeat (4) @(negedge CLK);
    run_meas(0, 0, 0);
    run_meas(0, 3, 0);
    run_meas(0, 1, 0);
    scan_stream(1, 0, vec);
    check("saturation", vec, exp_vec());

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NCH; i++)
        set_per(i, ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(560, 6)));
      repeat (4) @(negedge CLK);
      run_meas(1'($urandom_range(1, 0)), int'($urandom_range(NCH - 1, 0)), 0);
      scan_stream(1, 1'($urandom_range(1, 0)), vec);
      check("random_run", vec, exp_vec());
    end

    // abort in COUNT keeps the prior result
    set_per(1, 50);
    repeat (4) @(negedge CLK);
    run_meas(0, 1, 80);
    scan_stream(1, 0, vec);
    check("abort_retain", vec, exp_vec());

    // abort while idle does nothing
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_idle_done", MEAS_DONE, 0);
    check("abort_idle_busy", MEAS_BUSY, 0);

    // reset in the middle of a sweep and a shift
    for (int i = 0; i < NCH; i++) set_per(i, int'($urandom_range(300, 6)));
    repeat (4) @(negedge CLK);
    SWEEP = 1'b1;
    MEAS_TRIG = 1'b1;
    @(negedge CLK);
    MEAS_TRIG = 1'b0;
    repeat (30) @(negedge CLK);
    SCAN_LOAD = 1'b1;
    @(negedge CLK);
    SCAN_LOAD  = 1'b0;
    SCAN_SHIFT = 1'b1;
    SCAN_IN    = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_scan_out", SCAN_OUT, 0);
    check("rst_mid_busy", MEAS_BUSY, 0);
    check("rst_mid_en", EN_ROSC, 0);
    check("rst_mid_chsel", CH_SEL, 0);
    SCAN_SHIFT = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      mres[i] = 0; msat[i] = 0;
    end
    @(negedge CLK);
    check("rst_mid_idle", MEAS_BUSY, 0);
    scan_stream(1, 0, vec);
    check("rst_mid_cleared", vec, exp_vec());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
